// File: rtl/axil_reg_pkg.sv
// Shared register-map constants, response codes and address decode for axil_reg_responder.
// AXIL_REGS_CYCLE_COUNTER_EN maps the CYCLE_LO/CYCLE_HI offsets.
package axil_reg_pkg;

  localparam logic [31:0] REG_ID       = 32'h00;
  localparam logic [31:0] REG_SCRATCH  = 32'h04;
  localparam logic [31:0] REG_LED      = 32'h08;
  localparam logic [31:0] REG_CYCLE_LO = 32'h0C;
  localparam logic [31:0] REG_CYCLE_HI = 32'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic [2:0] {
    SEL_ID, SEL_SCRATCH, SEL_LED, SEL_CYC_LO, SEL_CYC_HI, SEL_NONE
  } reg_sel_e;

  typedef struct packed {
    logic [NUM_LANES-1:0][VEC_W-1:0] data;
    logic [NUM_LANES-1:0]            strb;
  } wbeat_t;

  // Byte-lane bits [1:0] never take part in the decode.
  function automatic reg_sel_e decode(input logic [31:0] addr);
    logic [31:0] a;
    a = {addr[31:2], 2'b00};
    case (a)
      REG_ID:       decode = SEL_ID;
      REG_SCRATCH:  decode = SEL_SCRATCH;
      REG_LED:      decode = SEL_LED;
`ifdef AXIL_REGS_CYCLE_COUNTER_EN
      REG_CYCLE_LO: decode = SEL_CYC_LO;
      REG_CYCLE_HI: decode = SEL_CYC_HI;
`endif
      default:      decode = SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/axil_wstrb_merge.sv
// Combinational per-byte merge: each lane takes wdata where wstrb is set, else keeps old data.
module axil_wstrb_merge
  import axil_reg_pkg::*;
#(
  parameter int LANES = NUM_LANES,
  parameter int LW    = VEC_W
) (
  input  logic [LANES-1:0][LW-1:0] old_data,
  input  logic [LANES-1:0][LW-1:0] wdata,
  input  logic [LANES-1:0]         wstrb,
  output logic [LANES-1:0][LW-1:0] merged
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign merged[i] = wstrb[i] ? wdata[i] : old_data[i];
  end

endmodule

// File: rtl/axil_reg_responder.sv
// AXI4-Lite register responder for the PCIe AXI-MM bridge master port: ID, SCRATCH, LED registers.
// AXIL_REGS_CYCLE_COUNTER_EN adds a 64-bit cycle counter readable at CYCLE_LO/CYCLE_HI.
module axil_reg_responder
  import axil_reg_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] ID_VALUE  = 32'h7C1E_0001,
  parameter logic [2:0]  LED_RESET = 3'b000
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  output logic [2:0]        led
);

  logic              aw_full, w_full;
  logic [ADDR_W-1:0] aw_addr_q;
  wbeat_t            w_q;
  logic [31:0]       scratch_q;
  logic [2:0]        led_q;

  // Readies are gated by reset so they read 0 while reset is held and open immediately after.
  assign s_axil_awready = axi_aresetn & ~aw_full;
  assign s_axil_wready  = axi_aresetn & ~w_full;
  assign s_axil_arready = axi_aresetn & ~s_axil_rvalid;
  assign led            = led_q;

  logic aw_hs, w_hs, ar_hs, commit;
  assign aw_hs = s_axil_awvalid & s_axil_awready;
  assign w_hs  = s_axil_wvalid & s_axil_wready;
  assign ar_hs = s_axil_arvalid & s_axil_arready;

  // A beat arriving this cycle bypasses its holder so the commit lands on the completing handshake edge.
  logic [ADDR_W-1:0] wr_addr;
  wbeat_t            wr_beat;
  assign wr_addr = aw_full ? aw_addr_q : s_axil_awaddr;
  assign wr_beat = w_full  ? w_q : {s_axil_wdata, s_axil_wstrb};
  assign commit  = (aw_full | aw_hs) & (w_full | w_hs) & ~s_axil_bvalid;

  reg_sel_e wsel, rsel;
  assign wsel = decode(32'(wr_addr));
  assign rsel = decode(32'(s_axil_araddr));

  logic [NUM_LANES-1:0][VEC_W-1:0] merge_old, merge_out;
  assign merge_old = (wsel == SEL_LED) ? {29'd0, led_q} : scratch_q;

  axil_wstrb_merge u_merge (
    .old_data (merge_old),
    .wdata    (wr_beat.data),
    .wstrb    (wr_beat.strb),
    .merged   (merge_out)
  );

  logic [1:0] wr_resp;
  always_comb begin
    wr_resp = RESP_OKAY;
    if (wsel == SEL_ID || wsel == SEL_NONE) wr_resp = RESP_SLVERR;
  end

`ifdef AXIL_REGS_CYCLE_COUNTER_EN
  logic [63:0] cycle_cnt;
  logic [31:0] cycle_hi_shadow;

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      cycle_cnt       <= '0;
      cycle_hi_shadow <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (ar_hs && rsel == SEL_CYC_LO) cycle_hi_shadow <= cycle_cnt[63:32];
    end
  end
`endif

  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rsel)
      SEL_ID:      rd_data = ID_VALUE;
      SEL_SCRATCH: rd_data = scratch_q;
      SEL_LED:     rd_data = {29'd0, led_q};
`ifdef AXIL_REGS_CYCLE_COUNTER_EN
      SEL_CYC_LO:  rd_data = cycle_cnt[31:0];
      SEL_CYC_HI:  rd_data = cycle_hi_shadow;
`endif
      default:     rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      aw_addr_q     <= '0;
      w_q           <= '0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= RESP_OKAY;
      s_axil_rvalid <= 1'b0;
      s_axil_rresp  <= RESP_OKAY;
      s_axil_rdata  <= '0;
      scratch_q     <= '0;
      led_q         <= LED_RESET;
    end else begin
      if (commit) begin
        aw_full       <= 1'b0;
        w_full        <= 1'b0;
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= wr_resp;
        if (wsel == SEL_SCRATCH) scratch_q <= merge_out;
        if (wsel == SEL_LED)     led_q     <= merge_out[0][2:0];
      end else begin
        if (aw_hs) begin
          aw_full   <= 1'b1;
          aw_addr_q <= s_axil_awaddr;
        end
        if (w_hs) begin
          w_full <= 1'b1;
          w_q    <= {s_axil_wdata, s_axil_wstrb};
        end
        if (s_axil_bvalid && s_axil_bready) s_axil_bvalid <= 1'b0;
      end

      // Reads sample the registers before this edge's write, so same-cycle reads see old data.
      if (ar_hs) begin
        s_axil_rvalid <= 1'b1;
        s_axil_rdata  <= rd_data;
        s_axil_rresp  <= rd_resp;
      end else if (s_axil_rvalid && s_axil_rready) begin
        s_axil_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axil_reg_responder.sv
// Randomized self-checking bench for axil_reg_responder against a register-map model.
// Define AXIL_REGS_CYCLE_COUNTER_EN to also exercise the cycle counter.
module tb_axil_reg_responder;

  localparam logic [31:0] ID_VAL = 32'h7C1E_0001;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [11:0] awaddr = '0, araddr = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [2:0]  led;

  always #5 clk = ~clk;

  axil_reg_responder dut (
    .axi_aclk(clk), .axi_aresetn(rstn),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .led(led)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference register file.
  logic [31:0] m_scratch;
  logic [2:0]  m_led;

  task automatic model_reset();
    m_scratch = 0;
    m_led     = 3'b000;
  endtask

  task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
    logic [31:0] cur;
    int w;
    w = int'(a) / 4;
    resp = 2'b10;
    if (w == 1 || w == 2) begin
      cur = (w == 1) ? m_scratch : {29'd0, m_led};
      for (int b = 0; b < 4; b++)
        if (s[b]) cur = (cur & ~(32'hFF << (8 * b))) | (d & (32'hFF << (8 * b)));
      if (w == 1) m_scratch = cur; else m_led = cur[2:0];
      resp = 2'b00;
    end
`ifdef AXIL_REGS_CYCLE_COUNTER_EN
    if (w == 3 || w == 4) resp = 2'b00;
`endif
  endtask

  task automatic model_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp,
                            output bit check_data);
    int w;
    w = int'(a) / 4;
    d = 0; resp = 2'b10; check_data = 1;
    case (w)
      0: begin d = ID_VAL;          resp = 2'b00; end
      1: begin d = m_scratch;       resp = 2'b00; end
      2: begin d = {29'd0, m_led};  resp = 2'b00; end
`ifdef AXIL_REGS_CYCLE_COUNTER_EN
      3, 4: begin resp = 2'b00; check_data = 0; end
`endif
      default: ;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 0; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    repeat (3) @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid",  bvalid,  0);
    chk("rst_rvalid",  rvalid,  0);
    chk("rst_led",     led,     0);
    chk("rst_rdata",   rdata,   0);
    rstn = 1;
    #1;
    chk("post_rst_ready", {awready, wready, arready}, 3'b111);
    model_reset();
  endtask

  // Drive AW and W; lead > 0 puts W that many cycles ahead of AW, lead < 0 puts AW ahead.
  task automatic drive_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int lead, input bit chk_lat);
    bit aw_done = 0, w_done = 0, haw, hw;
    int aw_start, w_start, t = 0;
    aw_start = (lead > 0) ? lead : 0;
    w_start  = (lead < 0) ? -lead : 0;
    while (!(aw_done && w_done) && t < 60) begin
      @(negedge clk);
      awvalid = !aw_done && t >= aw_start; awaddr = a;
      wvalid  = !w_done && t >= w_start;   wdata = d; wstrb = s;
      haw = awvalid && awready;
      hw  = wvalid && wready;
      @(posedge clk);
      if (haw) aw_done = 1;
      if (hw)  w_done = 1;
      t++;
    end
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    if (!(aw_done && w_done)) chk("wr_timeout", 0, 1);
    if (chk_lat) chk("b_latency", bvalid, 1);
  endtask

  task automatic collect_b(output logic [1:0] resp);
    int t = 0;
    while (!bvalid && t < 60) begin @(negedge clk); t++; end
    if (!bvalid) chk("b_timeout", 0, 1);
    resp = bresp;
    bready = 1;
    @(posedge clk);
    @(negedge clk);
    bready = 0;
  endtask

  task automatic axil_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input string tag);
    logic [1:0] got, exp;
    drive_write(a, d, s, lead, 1);
    collect_b(got);
    model_write(a, d, s, exp);
    chk({tag, "_bresp"}, got, exp);
  endtask

  task automatic axil_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit hs = 0;
    int t = 0;
    while (!hs && t < 60) begin
      @(negedge clk);
      arvalid = 1; araddr = a;
      hs = arready;
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    arvalid = 0;
    if (!hs) chk("rd_timeout", 0, 1);
    chk("r_latency", rvalid, 1);
    d = rdata; resp = rresp;
    rready = 1;
    @(posedge clk);
    @(negedge clk);
    rready = 0;
  endtask

  task automatic check_read(input logic [11:0] a, input string tag);
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    bit cd;
    model_read(a, ed, er, cd);
    axil_read(a, d, r);
    chk({tag, "_rresp"}, r, er);
    if (cd) chk({tag, "_rdata"}, d, ed);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    logic [11:0] a;

    do_reset();

    check_read(12'h000, "id");
    axil_write(12'h004, 32'hDEAD_BEEF, 4'hF, 3, "scr_wfirst");
    check_read(12'h004, "scr_deadbeef");
    axil_write(12'h004, 32'h0, 4'hF, 0, "scr_clear");
    axil_write(12'h004, 32'h1122_3344, 4'b0101, -2, "scr_strb");
    check_read(12'h004, "scr_strb");

    drive_write(12'h008, 32'hFFFF_FFFF, 4'hF, 0, 1);
    chk("led_after_commit", led, 3'b111);
    collect_b(resp);
    chk("led_bresp", resp, 2'b00);
    model_write(12'h008, 32'hFFFF_FFFF, 4'hF, resp);
    check_read(12'h008, "led_rd");

    check_read(12'h040, "unmapped");
    axil_write(12'h000, 32'h1234_5678, 4'hF, 0, "id_wr");
    check_read(12'h000, "id_after_wr");

    // B held off: holders reopen, a second write waits for the first B handshake.
    drive_write(12'h004, 32'hA5A5_0001, 4'hF, 0, 1);
    model_write(12'h004, 32'hA5A5_0001, 4'hF, resp);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bhold_bvalid", bvalid, 1);
      chk("bhold_bresp", bresp, 2'b00);
      chk("bhold_ready", {awready, wready}, 2'b11);
    end
    drive_write(12'h004, 32'h5A5A_0002, 4'hF, 1, 0);
    chk("bhold_aw_full", awready, 0);
    check_read(12'h004, "bhold_first_only");
    collect_b(resp);
    chk("bhold_b1", resp, 2'b00);
    model_write(12'h004, 32'h5A5A_0002, 4'hF, resp);
    collect_b(resp);
    chk("bhold_b2", resp, 2'b00);
    check_read(12'h004, "bhold_second");

    // Reset with an AW beat pending: it must be dropped.
    @(negedge clk); awvalid = 1; awaddr = 12'h004;
    @(posedge clk);
    @(negedge clk); awvalid = 0;
    do_reset();
    @(negedge clk); wvalid = 1; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk); wvalid = 0;
    repeat (3) begin @(negedge clk); chk("dropped_aw_no_b", bvalid, 0); end
    check_read(12'h004, "scr_after_rst");
    @(negedge clk); awvalid = 1; awaddr = 12'h008;
    @(posedge clk);
    @(negedge clk); awvalid = 0;
    chk("w_then_aw_b", bvalid, 1);
    collect_b(resp);
    chk("w_then_aw_bresp", resp, 2'b00);
    model_write(12'h008, 32'hCAFE_F00D, 4'hF, resp);
    check_read(12'h008, "led_after_rst");
    chk("led_pin", led, m_led);

`ifdef AXIL_REGS_CYCLE_COUNTER_EN
    begin
      logic [31:0] lo1, hi1, lo2, hi2;
      logic [63:0] c1, c2;
      axil_read(12'h00C, lo1, resp); chk("cyc_lo_resp", resp, 2'b00);
      axil_read(12'h010, hi1, resp); chk("cyc_hi_resp", resp, 2'b00);
      repeat (100) @(posedge clk);
      axil_read(12'h00C, lo2, resp);
      axil_read(12'h010, hi2, resp);
      c1 = {hi1, lo1}; c2 = {hi2, lo2};
      chk("cyc_diff_ge100", 64'(c2 - c1 >= 100), 1);
      chk("cyc_diff_bound", 64'(c2 - c1 < 400), 1);
    end
`endif

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2, 3, 4: a = 12'($urandom_range(0, 4) * 4 + $urandom_range(0, 3));
        5:             a = 12'h040;
        default:       a = 12'($urandom_range(0, 4095));
      endcase
      if ($urandom_range(0, 1) == 1)
        axil_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3, "rnd_wr");
      else
        check_read(a, "rnd_rd");
      chk("rnd_led_pin", led, m_led);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
